// File: rtl/spi_controller_if.sv
// spi_controller_if: host request/response and SPI pins of spi_controller; slave = controller side, master = host/peripheral side
interface spi_controller_if;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       nCS;
  logic       SCLK;
  logic       COPI;
  logic       CIPO;
  modport slave (input start, rw, addr, wdata, CIPO, output busy, done, rdata, nCS, SCLK, COPI);
  modport master (output start, rw, addr, wdata, CIPO, input busy, done, rdata, nCS, SCLK, COPI);
endinterface

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 initiator for 16-bit {rw, addr[6:0], data[7:0]} frames; ports clk, rst, bus (start/rw/addr/wdata in, busy/done/rdata out, nCS/SCLK/COPI out, CIPO in)
module spi_controller #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input logic        clk,
  input logic        rst,
  spi_controller_if.slave bus
);
  localparam int CW = $clog2((CLK_DIV > CS_GAP ? CLK_DIV : CS_GAP) + 1);
  typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, GAP} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [15:0]     f_q, f_d;
  logic [7:0]      cap_q, cap_d, rdata_q, rdata_d;
  logic            ncs_q, ncs_d, sclk_q, sclk_d, copi_q, copi_d, busy_q, busy_d, done_q, done_d;
  logic            last_div, last_gap;
  always_comb begin
    last_div = cnt_q == CW'(CLK_DIV - 1);
    last_gap = cnt_q == CW'(CS_GAP - 1);
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    bit_d    = bit_q;
    f_d      = f_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          state_d = LOW;
          bit_d   = 4'd15;
          f_d     = {bus.rw, bus.addr, bus.wdata};
        end
      end
      LOW: if (last_div) begin
        state_d = HIGH;
        cnt_d   = '0;
      end
      HIGH: if (last_div) begin
        state_d = bit_q == 4'd0 ? HOLD : LOW;
        bit_d   = bit_q == 4'd0 ? bit_q : bit_q - 4'd1;
        cnt_d   = '0;
      end
      HOLD: if (last_div) begin
        state_d = GAP;
        cnt_d   = '0;
      end
      GAP: if (last_gap) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Outputs are registered from the next state so every pin changes exactly on a state boundary
    ncs_d   = state_d == IDLE || state_d == GAP;
    sclk_d  = state_d == HIGH;
    copi_d  = !ncs_d && f_d[bit_d];
    busy_d  = state_d != IDLE;
    done_d  = state_d == GAP && cnt_d == CW'(CS_GAP - 1);
    // CIPO is sampled on the edge that raises SCLK, only for the data byte
    cap_d   = (state_q == LOW && state_d == HIGH && !bit_q[3]) ? {cap_q[6:0], bus.CIPO} : cap_q;
    rdata_d = (done_d && !f_q[15]) ? cap_q : rdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      f_q     <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
      ncs_q   <= 1'b1;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      f_q     <= f_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
      ncs_q   <= ncs_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign bus.nCS   = ncs_q;
  assign bus.SCLK  = sclk_q;
  assign bus.COPI  = copi_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed and random frames against a pin-level register peripheral model and frame timing arithmetic
module tb_spi_controller;
  localparam int CD = 4;
  localparam int CG = 4;
  localparam int T_DONE = 33 * CD + CG;
  localparam int T_LOW  = 33 * CD;
  localparam int T_PER  = 33 * CD + CG + 1;
  logic clk = 1'b0;
  logic rst;
  logic cipo;
  int checks = 0;
  int failures = 0;
  spi_controller_if bus();
  spi_controller #(.CLK_DIV(CD), .CS_GAP(CG)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.CIPO = cipo;
  always #5 clk = ~clk;
  int ncyc = 0, fall_t = 0, rise_t = 0, nfall = 0, rises = 0, last_rises = 0;
  int done_cnt = 0, done_t = 0, viol = 0, last_chg = -1000, last_rise = -1000;
  logic [15:0] rx = '0, last_frame = '0;
  logic [7:0] cipo_byte = '0;
  logic [7:0] regs [10];
  logic pn = 1'b1, ps = 1'b0, pc = 1'b0;
  logic [7:0] exp_rdata = '0;
  // Peripheral model: shifts COPI on SCLK rises, returns the addressed register on the data byte, commits writes only on exactly 16 rises
  always @(negedge clk) begin
    ncyc++;
    if (bus.done) begin
      done_cnt++;
      done_t = ncyc;
    end
    if (pn && !bus.nCS) begin
      fall_t = ncyc;
      nfall++;
      rises = 0;
      rx = '0;
    end
    if (!bus.nCS && bus.COPI !== pc) begin
      if (ncyc - last_rise < CD) viol++;
      last_chg = ncyc;
    end
    if (!bus.nCS && bus.SCLK && !ps) begin
      if (ncyc - last_chg < CD) viol++;
      last_rise = ncyc;
      rx = {rx[14:0], bus.COPI};
      rises++;
      if (rises == 8) cipo_byte = rx[6:0] < 7'd10 ? regs[rx[3:0]] : 8'h00;
    end
    if (!pn && bus.nCS) begin
      rise_t = ncyc;
      last_frame = rx;
      last_rises = rises;
      if (rises == 16 && rx[15] && rx[14:8] < 7'd10) regs[rx[11:8]] = rx[7:0];
    end
    cipo = (!bus.nCS && rises >= 8 && rises < 16) ? cipo_byte[15 - rises] : 1'bz;
    pn = bus.nCS;
    ps = bus.SCLK;
    pc = bus.COPI;
  end
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [79:0] snap();
    logic [79:0] s;
    for (int i = 0; i < 10; i++) s[i*8 +: 8] = regs[i];
    return s;
  endfunction
  task automatic frame(input logic r, input logic [6:0] a, input logic [7:0] d, input int poke);
    int t0, dc0, nf0, v0, n;
    logic [7:0] er;
    er = r ? exp_rdata : (a < 7'd10 ? regs[a[3:0]] : 8'h00);
    bus.start = 1'b1;
    bus.rw = r;
    bus.addr = a;
    bus.wdata = d;
    t0 = ncyc;
    dc0 = done_cnt;
    nf0 = nfall;
    v0 = viol;
    tick;
    bus.start = 1'b0;
    bus.rw = 1'($urandom);
    bus.addr = 7'($urandom);
    bus.wdata = 8'($urandom);
    n = 0;
    while (done_cnt == dc0 && n < 400) begin
      tick;
      n++;
      bus.start = n == poke;
      if (n == poke) begin
        bus.rw = ~r;
        bus.addr = ~a;
        bus.wdata = ~d;
      end
    end
    bus.start = 1'b0;
    chk("ncs_fall", 80'(fall_t - t0), 80'(1));
    chk("done_time", 80'(done_t - t0), 80'(T_DONE));
    chk("ncs_low_len", 80'(rise_t - fall_t), 80'(T_LOW));
    chk("sclk_rises", 80'(last_rises), 80'(16));
    chk("frame_bits", 80'(last_frame), 80'({r, a, d}));
    chk("rdata", 80'(bus.rdata), 80'(er));
    chk("copi_stable", 80'(viol - v0), 80'(0));
    tick;
    chk("busy_after_done", 80'({bus.busy, bus.done}), 80'(0));
    if (poke > 0) repeat (150) tick;
    chk("one_frame", 80'(nfall - nf0), 80'(1));
    chk("one_done", 80'(done_cnt - dc0), 80'(1));
    exp_rdata = er;
  endtask
  initial begin
    int t0, nf0, dc0, n;
    logic [79:0] s0;
    logic [6:0] ba;
    logic [7:0] bd;
    for (int i = 0; i < 10; i++) regs[i] = 8'h00;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.rw = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    repeat (3) tick;
    chk("reset_pins", 80'({bus.nCS, bus.SCLK, bus.COPI, bus.busy, bus.done}), 80'(5'b10000));
    chk("reset_rdata", 80'(bus.rdata), 80'(0));
    rst = 1'b0;
    tick;
    frame(1'b1, 7'h04, 8'hA5, 0);
    regs[2] = 8'h3C;
    frame(1'b0, 7'h02, 8'h66, 0);
    frame(1'b1, 7'h05, 8'h3E, 18);
    // Back-to-back: start held high, inputs changed after the first accept
    ba = 7'($urandom_range(0, 9));
    bd = 8'($urandom);
    bus.start = 1'b1;
    bus.rw = 1'b1;
    bus.addr = 7'h01;
    bus.wdata = 8'h11;
    t0 = ncyc;
    nf0 = nfall;
    dc0 = done_cnt;
    tick;
    bus.addr = ba;
    bus.wdata = bd;
    n = 0;
    while (nfall < nf0 + 2 && n < 400) begin
      tick;
      n++;
    end
    bus.start = 1'b0;
    chk("b2b_period", 80'(fall_t - t0 - 1), 80'(T_PER));
    chk("b2b_ncs_high", 80'(fall_t - rise_t), 80'(CG + 1));
    n = 0;
    while (done_cnt < dc0 + 2 && n < 400) begin
      tick;
      n++;
    end
    chk("b2b_frame2", 80'(last_frame), 80'({1'b1, ba, bd}));
    chk("b2b_dones", 80'(done_cnt - dc0), 80'(2));
    regs[3] = 8'h77;
    tick;
    // Reset after the 7th SCLK rise drops the frame
    bus.start = 1'b1;
    bus.rw = 1'b1;
    bus.addr = 7'h03;
    bus.wdata = 8'h99;
    dc0 = done_cnt;
    tick;
    bus.start = 1'b0;
    n = 0;
    while (!(rises == 7 && !bus.nCS) && n < 400) begin
      tick;
      n++;
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_mid_pins", 80'({bus.nCS, bus.SCLK, bus.busy}), 80'(3'b100));
    repeat (150) tick;
    chk("rst_mid_no_done", 80'(done_cnt - dc0), 80'(0));
    chk("rst_mid_rises", 80'(last_rises), 80'(7));
    chk("rst_mid_no_commit", 80'(regs[3]), 80'(8'h77));
    exp_rdata = 8'h00;
    frame(1'b1, 7'h03, 8'h42, 0);
    chk("post_rst_write", 80'(regs[3]), 80'(8'h42));
    // Register peripheral integration
    frame(1'b1, 7'h09, 8'h5A, 0);
    frame(1'b1, 7'h00, 8'hFF, 0);
    chk("reg9", 80'(regs[9]), 80'(8'h5A));
    chk("reg0", 80'(regs[0]), 80'(8'hFF));
    frame(1'b0, 7'h09, 8'h00, 0);
    frame(1'b0, 7'h00, 8'h00, 0);
    s0 = snap();
    frame(1'b1, 7'h0A, 8'hC3, 0);
    chk("addr_0a_no_effect", snap(), s0);
    for (int i = 0; i < 8; i++)
      frame(1'($urandom_range(0, 1)), 7'($urandom_range(0, 12)), 8'($urandom), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
